// File: rtl/darkroom_sensor_timestamper.sv
// Lighthouse photodiode capture: per-channel rising-edge timestamps and pulse widths,
// round-robin merged into an event FIFO that the HPS drains over an Avalon-MM slave.
module darkroom_sensor_timestamper #(
    parameter int NUM_SENSORS = 32,
    parameter int FIFO_DEPTH  = 64,
    parameter int WIDTH_BITS  = 16,
    parameter int MIN_WIDTH   = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_SENSORS-1:0] sensor_signal_i,
    input  logic [2:0]             address,
    input  logic                   read,
    output logic [31:0]            readdata,
    input  logic                   write,
    input  logic [31:0]            writedata,
    output logic                   irq
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CH_W    = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
    localparam int ENTRY_W = 40 + WIDTH_BITS;
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX = '1;
    localparam logic [WIDTH_BITS-1:0] WIDTH_MIN = WIDTH_BITS'(MIN_WIDTH);

    typedef enum logic [1:0] {
        WAIT_LOW = 2'd0,
        ARMED    = 2'd1,
        HIGH     = 2'd2,
        PENDING  = 2'd3
    } ch_state_e;

    logic [NUM_SENSORS-1:0] sync1_q, sync2_q, sync3_q;
    ch_state_e              state_q [NUM_SENSORS];
    logic [31:0]            ts_q    [NUM_SENSORS];
    logic [WIDTH_BITS-1:0]  width_q [NUM_SENSORS];
    logic [31:0]            timer_q;
    logic [NUM_SENSORS-1:0] mask_q, mask_d;
    logic [31:0]            drop_q, drop_d;
    logic [CH_W-1:0]        rr_q, rr_d;
    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W:0]         wr_q, rd_q;
    logic [31:0]            readdata_q, readdata_d;
    logic                   irq_q;

    logic [NUM_SENSORS-1:0] rise_s, pend_s, grant_s;
    logic                   grant_valid_s;
    logic [CH_W-1:0]        grant_idx_s;
    logic [PTR_W:0]         count_s;
    logic                   empty_s, full_s, push_s, pop_s;
    logic [ENTRY_W-1:0]     push_entry_s, head_s;
    logic [32:0]            drop_sum_s;

    function automatic logic [5:0] popcount(input logic [NUM_SENSORS-1:0] v);
        logic [5:0] c;
        c = 6'd0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            c = c + {5'd0, v[i]};
        end
        return c;
    endfunction

    assign rise_s  = sync2_q & ~sync3_q;
    assign count_s = wr_q - rd_q;
    assign empty_s = (wr_q == rd_q);
    assign full_s  = (count_s == (PTR_W+1)'(FIFO_DEPTH));
    assign push_s  = grant_valid_s;
    assign pop_s   = read && (address == 3'd1) && !empty_s;
    assign head_s  = mem_q[rd_q[PTR_W-1:0]];
    assign push_entry_s = {ts_q[grant_idx_s], 8'(grant_idx_s), width_q[grant_idx_s]};

    // Pending requests; a masked channel never competes even if its state has not yet left PENDING.
    always_comb begin
        pend_s = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            pend_s[i] = (state_q[i] == PENDING) && mask_q[i];
        end
    end

    // Round-robin arbiter starting at rr_q; grants only while the FIFO has room.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        grant_s       = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            int idx;
            idx = int'(rr_q) + i;
            if (idx >= NUM_SENSORS) begin
                idx = idx - NUM_SENSORS;
            end else begin
                idx = idx;
            end
            if (!grant_valid_s && pend_s[idx] && !full_s) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = CH_W'(idx);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
        if (grant_valid_s) begin
            grant_s[grant_idx_s] = 1'b1;
        end else begin
            grant_s = '0;
        end
    end

    // Next-state for pointer, mask and the saturating drop counter (a clear beats an increment).
    always_comb begin
        rr_d       = rr_q;
        mask_d     = mask_q;
        drop_sum_s = {1'b0, drop_q} + {27'd0, popcount(rise_s & pend_s & ~grant_s)};
        if (grant_valid_s) begin
            rr_d = (int'(grant_idx_s) == NUM_SENSORS - 1) ? '0 : grant_idx_s + CH_W'(1);
        end else begin
            rr_d = rr_q;
        end
        if (write && (address == 3'd4)) begin
            mask_d = writedata[NUM_SENSORS-1:0];
        end else begin
            mask_d = mask_q;
        end
        if (write && (address == 3'd3)) begin
            drop_d = 32'd0;
        end else if (drop_sum_s[32]) begin
            drop_d = 32'hFFFF_FFFF;
        end else begin
            drop_d = drop_sum_s[31:0];
        end
    end

    // Register read mux; readdata holds between reads.
    always_comb begin
        readdata_d = readdata_q;
        if (read) begin
            case (address)
                3'd0:    readdata_d = empty_s ? 32'd0 : head_s[ENTRY_W-1 -: 32];
                3'd1:    readdata_d = empty_s ? 32'd0 :
                                      {1'b1, 7'd0, head_s[WIDTH_BITS +: 8], 16'(head_s[WIDTH_BITS-1:0])};
                3'd2:    readdata_d = {14'd0, full_s, empty_s, 16'(count_s)};
                3'd3:    readdata_d = drop_q;
                3'd4:    readdata_d = 32'(mask_q);
                3'd5:    readdata_d = timer_q;
                default: readdata_d = 32'd0;
            endcase
        end else begin
            readdata_d = readdata_q;
        end
    end

    // Control registers. Synchronisers reset high so a pulse already present at release is not seen as an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            sync3_q    <= '1;
            timer_q    <= 32'd0;
            mask_q     <= '1;
            drop_q     <= 32'd0;
            rr_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            readdata_q <= 32'd0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= sensor_signal_i;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            timer_q    <= timer_q + 32'd1;
            mask_q     <= mask_d;
            drop_q     <= drop_d;
            rr_q       <= rr_d;
            wr_q       <= push_s ? wr_q + (PTR_W+1)'(1) : wr_q;
            rd_q       <= pop_s ? rd_q + (PTR_W+1)'(1) : rd_q;
            readdata_q <= readdata_d;
            irq_q      <= !empty_s;
        end
    end

    // FIFO storage.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_q[wr_q[PTR_W-1:0]] <= push_entry_s;
        end
    end

    // Per-channel capture FSMs.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (reset) begin
                state_q[i] <= WAIT_LOW;
                ts_q[i]    <= 32'd0;
                width_q[i] <= '0;
            end else if (!mask_q[i]) begin
                state_q[i] <= WAIT_LOW;
            end else begin
                case (state_q[i])
                    WAIT_LOW: state_q[i] <= sync2_q[i] ? WAIT_LOW : ARMED;
                    ARMED: begin
                        if (rise_s[i]) begin
                            state_q[i] <= HIGH;
                            ts_q[i]    <= timer_q;
                            width_q[i] <= WIDTH_BITS'(1);
                        end else begin
                            state_q[i] <= ARMED;
                        end
                    end
                    HIGH: begin
                        if (sync2_q[i]) begin
                            width_q[i] <= (width_q[i] == WIDTH_MAX) ? WIDTH_MAX : width_q[i] + WIDTH_BITS'(1);
                        end else if (width_q[i] >= WIDTH_MIN) begin
                            state_q[i] <= PENDING;
                        end else begin
                            state_q[i] <= ARMED;
                        end
                    end
                    PENDING: begin
                        if (grant_s[i] && rise_s[i]) begin
                            state_q[i] <= HIGH;
                            ts_q[i]    <= timer_q;
                            width_q[i] <= WIDTH_BITS'(1);
                        end else if (grant_s[i]) begin
                            state_q[i] <= sync2_q[i] ? WAIT_LOW : ARMED;
                        end else begin
                            state_q[i] <= PENDING;
                        end
                    end
                    default: state_q[i] <= WAIT_LOW;
                endcase
            end
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_darkroom_sensor_timestamper.sv
// Scoreboard bench: stimulus queues expected read responses and captured events,
// an independent monitor compares each Avalon read response as it appears.
module tb_darkroom_sensor_timestamper;
    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int WB    = 12;
    localparam int MINW  = 4;
    localparam int K_EXACT = 0;
    localparam int K_TSCAP = 1;
    localparam int K_EVENT = 2;

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] val;
        bit          chk_irq;
        bit          irq_val;
    } rd_exp_t;

    typedef struct {
        int          ch;
        logic [31:0] ts;
        int          width;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  sensor = '0;
    logic [2:0]    address = 3'd0;
    logic          read = 1'b0;
    logic [31:0]   readdata;
    logic          write = 1'b0;
    logic [31:0]   writedata = 32'd0;
    logic          irq;

    rd_exp_t     exp_q[$];
    ev_t         ev_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] tm = 32'd0;
    bit          stim_done = 1'b0;

    darkroom_sensor_timestamper #(
        .NUM_SENSORS(N), .FIFO_DEPTH(DEPTH), .WIDTH_BITS(WB), .MIN_WIDTH(MINW)
    ) dut (
        .clock(clock), .reset(reset), .sensor_signal_i(sensor), .address(address),
        .read(read), .readdata(readdata), .write(write), .writedata(writedata), .irq(irq)
    );

    always #5 clock = ~clock;

    // Reference timer: cleared by reset, otherwise one tick per cycle.
    always @(posedge clock) tm <= reset ? 32'd0 : tm + 32'd1;

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic rd(input int a, input int kind, input logic [31:0] v, input bit ci, input bit iv);
        rd_exp_t e;
        e.kind = kind; e.addr = a; e.val = v; e.chk_irq = ci; e.irq_val = iv;
        exp_q.push_back(e);
        address = 3'(a);
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic wr(input int a, input logic [31:0] v);
        address = 3'(a);
        writedata = v;
        write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic add_ev(input int ch, input logic [31:0] ts, input int w);
        ev_t e;
        e.ch = ch; e.ts = ts;
        e.width = (w > (1 << WB) - 1) ? (1 << WB) - 1 : w;
        if (w >= MINW) ev_q.push_back(e);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rd(0, K_TSCAP, 32'd0, 1'b1, 1'b1);
            rd(1, K_EVENT, 32'd0, 1'b0, 1'b0);
            idle(1);
        end
        rd(1, K_EXACT, 32'd0, 1'b0, 1'b0);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(5);
    endtask

    // Stimulus
    initial begin
        int          st [N];
        int          wd [N];
        logic [31:0] tsx [N];
        bit          on [N];
        int          nev;
        logic [31:0] t;
        rd_exp_t     e;

        idle(3);
        reset = 1'b0;
        idle(5);
        rd(0, K_EXACT, 32'd0, 1'b1, 1'b0);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);
        rd(3, K_EXACT, 32'd0, 1'b0, 1'b0);
        rd(4, K_EXACT, 32'hFFFF_FFFF, 1'b0, 1'b0);
        rd(6, K_EXACT, 32'd0, 1'b0, 1'b0);
        wr(5, 32'h1234_5678);
        rd(5, K_EXACT, tm, 1'b0, 1'b0);

        while (tm != 32'd1000) @(negedge clock);
        sensor[5] = 1'b1;
        idle(100);
        sensor[5] = 1'b0;
        idle(6);
        rd(0, K_EXACT, 32'd1002, 1'b1, 1'b1);
        rd(1, K_EXACT, 32'h8005_0064, 1'b0, 1'b0);
        rd(1, K_EXACT, 32'd0, 1'b0, 1'b0);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);

        sensor[0] = 1'b1; idle(3); sensor[0] = 1'b0; idle(8);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);
        rd(3, K_EXACT, 32'd0, 1'b0, 1'b0);
        t = tm + 32'd2;
        sensor[0] = 1'b1; idle(4); sensor[0] = 1'b0; idle(8);
        add_ev(0, t, 4);
        drain(1);

        for (int b = 0; b < 3; b++) begin
            for (int ch = 0; ch < N; ch++) begin
                on[ch] = ($urandom_range(0, 2) == 0);
                st[ch] = $urandom_range(0, 20);
                wd[ch] = $urandom_range(1, 12);
                tsx[ch] = 32'd0;
            end
            for (int c = 0; c < 36; c++) begin
                for (int ch = 0; ch < N; ch++) begin
                    if (on[ch] && c == st[ch]) tsx[ch] = tm + 32'd2;
                    sensor[ch] = on[ch] && (c >= st[ch]) && (c < st[ch] + wd[ch]);
                end
                @(negedge clock);
            end
            idle(8);
            nev = 0;
            for (int ch = 0; ch < N; ch++) begin
                if (on[ch] && wd[ch] >= MINW) begin
                    add_ev(ch, tsx[ch], wd[ch]);
                    nev++;
                end
            end
            drain(nev);
        end

        do_reset();
        t = tm + 32'd2;
        sensor = '1; idle(50); sensor = '0; idle(8);
        for (int ch = 0; ch < N; ch++) begin
            rd(0, K_EXACT, t, 1'b1, 1'b1);
            rd(1, K_EXACT, 32'h8000_0032 | (32'(ch) << 16), 1'b0, 1'b0);
            idle(1);
        end
        rd(1, K_EXACT, 32'd0, 1'b0, 1'b0);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);

        do_reset();
        t = tm + 32'd2;
        sensor[7:0] = 8'hFF; idle(10); sensor[7:0] = 8'h00; idle(10);
        for (int ch = 0; ch < 8; ch++) add_ev(ch, t, 10);
        rd(2, K_EXACT, 32'h0002_0004, 1'b1, 1'b1);
        sensor[7:4] = 4'hF; idle(6); sensor[7:4] = 4'h0; idle(6);
        rd(3, K_EXACT, 32'd4, 1'b0, 1'b0);
        rd(2, K_EXACT, 32'h0002_0004, 1'b0, 1'b0);
        wr(3, 32'd0);
        rd(3, K_EXACT, 32'd0, 1'b0, 1'b0);
        drain(8);

        wr(4, 32'hFFFF_FFFE);
        rd(4, K_EXACT, 32'hFFFF_FFFE, 1'b0, 1'b0);
        idle(2);
        t = tm + 32'd2;
        sensor[1:0] = 2'b11; idle(8); sensor[1:0] = 2'b00; idle(8);
        add_ev(1, t, 8);
        drain(1);
        sensor[1] = 1'b1; idle(5);
        wr(4, 32'hFFFF_FFFC);
        idle(10); sensor[1] = 1'b0; idle(6);
        wr(4, 32'hFFFF_FFFF);
        idle(5);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);
        t = tm + 32'd2;
        sensor[1] = 1'b1; idle(5); sensor[1] = 1'b0; idle(8);
        add_ev(1, t, 5);
        drain(1);

        t = tm + 32'd2;
        sensor[2] = 1'b1; idle(5000); sensor[2] = 1'b0; idle(8);
        rd(0, K_EXACT, t, 1'b1, 1'b1);
        rd(1, K_EXACT, 32'h8002_0FFF, 1'b0, 1'b0);
        rd(1, K_EXACT, 32'd0, 1'b0, 1'b0);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);

        sensor[2] = 1'b1; idle(100);
        e.kind = K_EXACT; e.addr = 5; e.val = 32'd0; e.chk_irq = 1'b0; e.irq_val = 1'b0;
        exp_q.push_back(e);
        reset = 1'b1; address = 3'd5; read = 1'b1;
        @(negedge clock);
        reset = 1'b0; read = 1'b0;
        idle(20);
        rd(5, K_EXACT, tm, 1'b1, 1'b0);
        rd(0, K_EXACT, 32'd0, 1'b0, 1'b0);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);
        sensor[2] = 1'b0; idle(10);
        rd(2, K_EXACT, 32'h0001_0000, 1'b1, 1'b0);
        t = tm + 32'd2;
        sensor[2] = 1'b1; idle(6); sensor[2] = 1'b0; idle(8);
        add_ev(2, t, 6);
        drain(1);

        idle(3);
        stim_done = 1'b1;
    end

    // Monitor: every read strobe seen at a rising edge is checked at the following falling edge.
    initial begin
        logic [31:0] rdv;
        logic [31:0] cap_ts;
        logic [31:0] want;
        rd_exp_t     e;
        ev_t         ev;
        bit          found;
        int          cyc;
        cap_ts = 32'd0;
        cyc = 0;
        while (!stim_done && cyc < 60000) begin
            @(posedge clock);
            cyc++;
            if (read) begin
                @(negedge clock);
                rdv = readdata;
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_read: got %h required no read", rdv);
                end else begin
                    e = exp_q.pop_front();
                    if (e.chk_irq) begin
                        n_cmp++;
                        if (irq !== e.irq_val) begin
                            n_bad++;
                            $display("FAIL irq@addr%0d: got %b required %b", e.addr, irq, e.irq_val);
                        end
                    end
                    case (e.kind)
                        K_EXACT: begin
                            n_cmp++;
                            if (rdv !== e.val) begin
                                n_bad++;
                                $display("FAIL rd_addr%0d: got %h required %h", e.addr, rdv, e.val);
                            end
                        end
                        K_TSCAP: cap_ts = rdv;
                        default: begin
                            found = 1'b0;
                            for (int i = 0; i < ev_q.size(); i++) begin
                                if (!found && ev_q[i].ch == int'(rdv[23:16])) begin
                                    ev = ev_q[i];
                                    ev_q.delete(i);
                                    found = 1'b1;
                                end
                            end
                            n_cmp++;
                            if (!found) begin
                                n_bad++;
                                $display("FAIL event_unexpected: got %h required a queued event", rdv);
                            end else begin
                                want = {1'b1, 7'd0, 8'(ev.ch), 16'(ev.width)};
                                if (rdv !== want) begin
                                    n_bad++;
                                    $display("FAIL event_word ch%0d: got %h required %h", ev.ch, rdv, want);
                                end
                                n_cmp++;
                                if (cap_ts !== ev.ts) begin
                                    n_bad++;
                                    $display("FAIL event_ts ch%0d: got %0d required %0d", ev.ch, cap_ts, ev.ts);
                                end
                            end
                        end
                    endcase
                end
            end
        end
        n_cmp++;
        if (!stim_done) begin
            n_bad++;
            $display("FAIL timeout: got %0d cycles required completion", cyc);
        end
        n_cmp++;
        if (ev_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_events: got %0d required 0", ev_q.size());
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_reads: got %0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
